// File: rtl/debounce_pkg.sv
// Shared helpers for the debounce_array block.
package debounce_pkg;

    // Bits needed to hold any value in 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, polarity normalisation,
// stability window, and the hold / auto-repeat event counters.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter bit active_low_p   = 1'b1,
    parameter int stable_ticks_p = 16,
    parameter int hold_ticks_p   = 0,
    parameter int repeat_ticks_p = 0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic tick_i,
    input  logic button_i,
    output logic pressed_o,
    output logic down_o,
    output logic up_o,
    output logic hold_o,
    output logic repeat_o
);

    localparam int STAB_W = cnt_width(stable_ticks_p);
    localparam int HOLD_W = cnt_width(hold_ticks_p);
    localparam int REP_W  = cnt_width(repeat_ticks_p);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(stable_ticks_p - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(hold_ticks_p);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((hold_ticks_p > 0) ? hold_ticks_p - 1 : 0);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((repeat_ticks_p > 0) ? repeat_ticks_p - 1 : 0);

    localparam bit HOLD_EN = (hold_ticks_p > 0);
    localparam bit REP_EN  = (hold_ticks_p > 0) && (repeat_ticks_p > 0);

    logic              sync1_q, sync2_q;
    logic              pressed_q, pressed_d;
    logic              down_q, down_d;
    logic              up_q, up_d;
    logic              hold_q, hold_d;
    logic              repeat_q, repeat_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              lvl;
    logic              toggle;

    // Normalised level: 1 means the button is physically pressed.
    assign lvl = sync2_q ^ active_low_p;

    // Stability window: any agreement restarts it, a full window of ticks flips the level.
    always_comb begin
        stab_d    = stab_q;
        pressed_d = pressed_q;
        down_d    = 1'b0;
        up_d      = 1'b0;
        toggle    = 1'b0;
        if (lvl == pressed_q) begin
            stab_d = '0;
        end else if (tick_i) begin
            if (stab_q == STAB_LAST) begin
                toggle    = 1'b1;
                pressed_d = lvl;
                stab_d    = '0;
                down_d    = lvl;
                up_d      = ~lvl;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    // Hold and repeat timing; the release cycle itself never produces hold or repeat.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rep_d      = rep_q;
        hold_d     = 1'b0;
        repeat_d   = 1'b0;
        if (!pressed_q || toggle) begin
            hold_cnt_d = '0;
            rep_d      = '0;
        end else if (tick_i && HOLD_EN) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                hold_d     = (hold_cnt_q == HOLD_LAST);
            end else if (REP_EN) begin
                if (rep_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    rep_d    = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
        end
    end

    // State registers; synchroniser resets to the released pin level.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q    <= active_low_p;
            sync2_q    <= active_low_p;
            pressed_q  <= 1'b0;
            down_q     <= 1'b0;
            up_q       <= 1'b0;
            hold_q     <= 1'b0;
            repeat_q   <= 1'b0;
            stab_q     <= '0;
            hold_cnt_q <= '0;
            rep_q      <= '0;
        end else begin
            sync1_q    <= button_i;
            sync2_q    <= sync1_q;
            pressed_q  <= pressed_d;
            down_q     <= down_d;
            up_q       <= up_d;
            hold_q     <= hold_d;
            repeat_q   <= repeat_d;
            stab_q     <= stab_d;
            hold_cnt_q <= hold_cnt_d;
            rep_q      <= rep_d;
        end
    end

    assign pressed_o = pressed_q;
    assign down_o    = down_q;
    assign up_o      = up_q;
    assign hold_o    = hold_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/debounce_array.sv
// Multi-channel button conditioner: shared tick prescaler plus one
// debounce_channel per input pin.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int channels_p     = 4,
    parameter bit active_low_p   = 1'b1,
    parameter int tick_div_p     = 1000,
    parameter int stable_ticks_p = 16,
    parameter int hold_ticks_p   = 0,
    parameter int repeat_ticks_p = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [channels_p-1:0] button_i,
    output logic [channels_p-1:0] pressed_o,
    output logic [channels_p-1:0] down_o,
    output logic [channels_p-1:0] up_o,
    output logic [channels_p-1:0] hold_o,
    output logic [channels_p-1:0] repeat_o
);

    localparam int               DIV_W    = cnt_width(tick_div_p - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(tick_div_p - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    // One-cycle tick on the last count of the prescaler.
    assign tick = (div_q == DIV_LAST);

    // Prescaler next state: wrap to zero after the tick.
    always_comb begin
        div_d = div_q + 1'b1;
        if (tick) begin
            div_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar g = 0; g < channels_p; g++) begin : g_ch
        debounce_channel #(
            .active_low_p  (active_low_p),
            .stable_ticks_p(stable_ticks_p),
            .hold_ticks_p  (hold_ticks_p),
            .repeat_ticks_p(repeat_ticks_p)
        ) u_ch (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .tick_i   (tick),
            .button_i (button_i[g]),
            .pressed_o(pressed_o[g]),
            .down_o   (down_o[g]),
            .up_o     (up_o[g]),
            .hold_o   (hold_o[g]),
            .repeat_o (repeat_o[g])
        );
    end

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array: main instance with a tick every cycle,
// plus a single-channel instance with a slower prescaler.
module tb_debounce_array;

    localparam int CH = 4;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic reset_n_i;
    always #5 clk_i = ~clk_i;

    logic [CH-1:0] button_i, pressed_o, down_o, up_o, hold_o, repeat_o;
    logic          button_b, pressed_b, down_b, up_b, hold_b, repeat_b;

    debounce_array #(
        .channels_p(CH), .active_low_p(1'b1), .tick_div_p(1),
        .stable_ticks_p(4), .hold_ticks_p(10), .repeat_ticks_p(5)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .button_i(button_i),
        .pressed_o(pressed_o), .down_o(down_o), .up_o(up_o),
        .hold_o(hold_o), .repeat_o(repeat_o)
    );

    debounce_array #(
        .channels_p(1), .active_low_p(1'b1), .tick_div_p(3),
        .stable_ticks_p(2), .hold_ticks_p(0), .repeat_ticks_p(0)
    ) dut_b (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .button_i(button_b),
        .pressed_o(pressed_b), .down_o(down_b), .up_o(up_b),
        .hold_o(hold_b), .repeat_o(repeat_b)
    );

    // ---------------- scoreboard ----------------
    int          total;
    int          bad;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [CH-1:0] prev_p;
    logic [31:0] acc;
    int          lat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Event code: kind in the upper half, edge number (after stimulus) in the lower half.
    // kinds: 1 down, 2 up, 3 hold, 4 repeat, 5 pressed rise, 6 pressed fall
    function automatic logic [31:0] ev(input int kind, input int edge_n);
        return (32'(kind) << 16) | 32'(edge_n);
    endfunction

    // Advance one clock edge and log every event on channel ch.
    task automatic step_log(input int ch, input int edge_n);
        @(negedge clk_i);
        if (down_o[ch])   got_q.push_back(ev(1, edge_n));
        if (up_o[ch])     got_q.push_back(ev(2, edge_n));
        if (hold_o[ch])   got_q.push_back(ev(3, edge_n));
        if (repeat_o[ch]) got_q.push_back(ev(4, edge_n));
        if (pressed_o[ch] && !prev_p[ch]) got_q.push_back(ev(5, edge_n));
        if (!pressed_o[ch] && prev_p[ch]) got_q.push_back(ev(6, edge_n));
        prev_p[ch] = pressed_o[ch];
    endtask

    task automatic check_events(input string tag);
        check_val({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_val(tag, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        total     = 0;
        bad       = 0;
        prev_p    = '0;
        button_i  = '1;
        button_b  = 1'b1;
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_val("reset_outputs", 32'({pressed_o, down_o, up_o, hold_o, repeat_o}), 32'h0);
        check_val("reset_outputs_b", 32'({pressed_b, down_b, up_b, hold_b, repeat_b}), 32'h0);

        // Idle pins after reset release: nothing may happen.
        reset_n_i = 1'b1;
        acc = '0;
        repeat (200) begin
            @(negedge clk_i);
            acc = acc | 32'({pressed_o, down_o, up_o, hold_o, repeat_o, pressed_b, down_b, up_b, hold_b, repeat_b});
        end
        check_val("idle_200", acc, 32'h0);

        // ch0 clean press, held through hold and repeats, then released.
        button_i[0] = 1'b0;
        for (int e = 1; e <= 28; e++) step_log(0, e);
        button_i[0] = 1'b1;
        for (int e = 29; e <= 40; e++) step_log(0, e);
        exp_q = '{ev(1, 6), ev(5, 6), ev(3, 16), ev(4, 21), ev(4, 26), ev(4, 31), ev(2, 34), ev(6, 34)};
        check_events("ch0_press");

        // ch1 bouncing every 3 cycles, last level pressed; released right when hold would fire.
        for (int e = 0; e <= 39; e++) begin
            if (e % 3 == 0 && e <= 30) button_i[1] = ~button_i[1];
            step_log(1, e + 1);
        end
        button_i[1] = 1'b1;
        for (int e = 41; e <= 55; e++) step_log(1, e);
        exp_q = '{ev(1, 36), ev(5, 36), ev(2, 46), ev(6, 46)};
        check_events("ch1_bounce");

        // ch2 long hold; release lands on what would have been a repeat edge.
        button_i[2] = 1'b0;
        for (int e = 1; e <= 45; e++) step_log(2, e);
        button_i[2] = 1'b1;
        for (int e = 46; e <= 60; e++) step_log(2, e);
        exp_q = '{ev(1, 6), ev(5, 6), ev(3, 16), ev(4, 21), ev(4, 26), ev(4, 31),
                  ev(4, 36), ev(4, 41), ev(4, 46), ev(2, 51), ev(6, 51)};
        check_events("ch2_hold");

        // All channels pressed in the same cycle.
        button_i = '0;
        repeat (5) @(negedge clk_i);
        check_val("all_down_early", 32'(down_o), 32'h0);
        @(negedge clk_i);
        check_val("all_down", 32'(down_o), 32'hF);
        check_val("all_pressed", 32'(pressed_o), 32'hF);
        @(negedge clk_i);
        check_val("all_down_width", 32'(down_o), 32'h0);
        repeat (9) @(negedge clk_i);
        check_val("all_hold", 32'(hold_o), 32'hF);
        button_i = '1;
        repeat (6) @(negedge clk_i);
        check_val("all_up", 32'(up_o), 32'hF);
        check_val("all_released", 32'(pressed_o), 32'h0);
        repeat (5) @(negedge clk_i);

        // Slower prescaler: accept latency must fall inside the tick window.
        button_b = 1'b0;
        lat = -1;
        for (int e = 1; e <= 20 && lat < 0; e++) begin
            @(negedge clk_i);
            if (pressed_b) begin
                lat = e;
                check_val("b_down_with_level", 32'(down_b), 32'h1);
            end
        end
        check_val("b_latency_window", 32'((lat >= 6) && (lat <= 8)), 32'h1);
        button_b = 1'b1;
        repeat (15) @(negedge clk_i);
        check_val("b_released", 32'(pressed_b), 32'h0);

        // Reset mid-window: ch0 already pressed, ch3 at count 3 of 4.
        button_i[0] = 1'b0;
        repeat (10) @(negedge clk_i);
        button_i[3] = 1'b0;
        repeat (5) @(negedge clk_i);
        check_val("pre_reset_level", 32'(pressed_o), 32'h1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_val("async_reset_outputs", 32'({pressed_o, down_o, up_o, hold_o, repeat_o}), 32'h0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        prev_p = '0;
        for (int e = 1; e <= 8; e++) step_log(3, e);
        exp_q = '{ev(1, 6), ev(5, 6)};
        check_events("ch3_after_reset");
        check_val("ch0_after_reset", 32'(pressed_o[0]), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
